dependency_check_block: RTL and testbench

Decode-stage block for the 8-bit MIPS-style pipeline. It registers the decoded fields of a 20-bit instruction: opcode, destination register, immediate, and memory controls. It also compares the instruction's source registers against the destinations of the two previous instructions. From that comparison it drives forwarding mux selects for ALU operands A and B. It sits between instruction fetch and the execute stage.

---
 rtl/dependency_check_block.sv | 120 ++++++++++++
 tb/tb_dependency_check_block.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dependency_check_block.sv
// Decode stage: registers decoded instruction fields and memory controls, and
// derives ALU operand forwarding selects from a two-deep destination history.
module dependency_check_block (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] ins,
    output logic [1:0]  mux_sel_a,
    output logic [1:0]  mux_sel_b,
    output logic        imm_sel,
    output logic [7:0]  imm,
    output logic        mem_en_dec,
    output logic        mem_rw_dec,
    output logic        mem_mux_sel_dec,
    output logic [4:0]  RW_dec,
    output logic [4:0]  op_dec
);

    localparam logic [1:0] SelReg = 2'b00;
    localparam logic [1:0] SelEx  = 2'b01;
    localparam logic [1:0] SelMem = 2'b10;

    localparam logic [4:0] OpLoad  = 5'b11000;
    localparam logic [4:0] OpStore = 5'b11001;

    logic [4:0] op, rw, ra, rb;
    logic [7:0] imm_field;

    assign op        = ins[19:15];
    assign rw        = ins[14:10];
    assign ra        = ins[9:5];
    assign rb        = ins[4:0];
    assign imm_field = ins[7:0];

    // Destination history: h1 is the instruction now in EX, h2 the one in MEM/WB.
    logic [4:0] h1_dest_q, h2_dest_q;
    logic       h1_valid_q, h2_valid_q;

    logic       use_a, use_b, writes_reg;
    logic [4:0] src_a;
    logic       imm_sel_d, mem_en_d, mem_rw_d, mem_mux_sel_d;
    logic [1:0] sel_a_d, sel_b_d;

    always_comb begin
        use_a         = 1'b0;
        use_b         = 1'b0;
        src_a         = ra;
        writes_reg    = 1'b0;
        imm_sel_d     = 1'b0;
        mem_en_d      = 1'b0;
        mem_rw_d      = 1'b0;
        mem_mux_sel_d = 1'b0;
        if (op[4] == 1'b0) begin
            use_a      = 1'b1;
            use_b      = 1'b1;
            writes_reg = 1'b1;
        end else if (op[3] == 1'b0) begin
            // Immediate ALU reads and writes the RW register.
            use_a      = 1'b1;
            src_a      = rw;
            writes_reg = 1'b1;
            imm_sel_d  = 1'b1;
        end else if (op == OpLoad) begin
            writes_reg    = 1'b1;
            imm_sel_d     = 1'b1;
            mem_en_d      = 1'b1;
            mem_mux_sel_d = 1'b1;
        end else if (op == OpStore) begin
            use_a     = 1'b1;
            src_a     = rw;
            imm_sel_d = 1'b1;
            mem_en_d  = 1'b1;
            mem_rw_d  = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                           input logic v1, input logic [4:0] d1,
                                           input logic v2, input logic [4:0] d2);
        if (!used)                 return SelReg;
        else if (v1 && d1 == src)  return SelEx;
        else if (v2 && d2 == src)  return SelMem;
        else                       return SelReg;
    endfunction

    assign sel_a_d = fwd_sel(use_a, src_a, h1_valid_q, h1_dest_q, h2_valid_q, h2_dest_q);
    assign sel_b_d = fwd_sel(use_b, rb, h1_valid_q, h1_dest_q, h2_valid_q, h2_dest_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            mux_sel_a       <= SelReg;
            mux_sel_b       <= SelReg;
            imm_sel         <= 1'b0;
            imm             <= '0;
            mem_en_dec      <= 1'b0;
            mem_rw_dec      <= 1'b0;
            mem_mux_sel_dec <= 1'b0;
            RW_dec          <= '0;
            op_dec          <= '0;
            h1_dest_q       <= '0;
            h1_valid_q      <= 1'b0;
            h2_dest_q       <= '0;
            h2_valid_q      <= 1'b0;
        end else begin
            mux_sel_a       <= sel_a_d;
            mux_sel_b       <= sel_b_d;
            imm_sel         <= imm_sel_d;
            imm             <= imm_field;
            mem_en_dec      <= mem_en_d;
            mem_rw_dec      <= mem_rw_d;
            mem_mux_sel_dec <= mem_mux_sel_d;
            RW_dec          <= rw;
            op_dec          <= op;
            h2_dest_q       <= h1_dest_q;
            h2_valid_q      <= h1_valid_q;
            h1_dest_q       <= rw;
            h1_valid_q      <= writes_reg;
        end
    end

endmodule

// File: tb/tb_dependency_check_block.sv
// Directed bench for dependency_check_block: decode fields, memory controls and
// forwarding selects checked against hand-computed vectors.
module tb_dependency_check_block;

    logic        clk;
    logic        reset;
    logic [19:0] ins;
    logic [1:0]  mux_sel_a, mux_sel_b;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        mem_en_dec, mem_rw_dec, mem_mux_sel_dec;
    logic [4:0]  RW_dec, op_dec;

    int n_cmp  = 0;
    int n_fail = 0;

    // {sel_a, sel_b, imm_sel, imm, mem_en, mem_rw, mem_mux_sel, RW, op}
    logic [25:0] outs;
    assign outs = {mux_sel_a, mux_sel_b, imm_sel, imm, mem_en_dec, mem_rw_dec,
                   mem_mux_sel_dec, RW_dec, op_dec};

    dependency_check_block dut (
        .clk             (clk),
        .reset           (reset),
        .ins             (ins),
        .mux_sel_a       (mux_sel_a),
        .mux_sel_b       (mux_sel_b),
        .imm_sel         (imm_sel),
        .imm             (imm),
        .mem_en_dec      (mem_en_dec),
        .mem_rw_dec      (mem_rw_dec),
        .mem_mux_sel_dec (mem_mux_sel_dec),
        .RW_dec          (RW_dec),
        .op_dec          (op_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [19:0] i);
        reset = rst;
        ins   = i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [25:0] exp;
        step(1'b1, 20'($urandom));
        step(1'b1, 20'($urandom));
        exp = '0;
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", outs, exp);
        end
        step(1'b0, 20'h00443);
        exp = {2'b00, 2'b00, 1'b0, 8'h43, 1'b0, 1'b0, 1'b0, 5'd1, 5'b00000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL first_after_reset: got %h want %h", outs, exp);
        end
    endtask

    task automatic test_immediate_and_forwarding();
        logic [25:0] exp;
        step(1'b0, 20'hA1020);
        exp = {2'b00, 2'b00, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 5'd4, 5'b10100};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL imm_alu: got %h want %h", outs, exp);
        end
        step(1'b0, 20'hA1020);
        exp = {2'b01, 2'b00, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 5'd4, 5'b10100};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL imm_alu_repeat: got %h want %h", outs, exp);
        end
        step(1'b0, 20'h21424);
        exp = {2'b00, 2'b01, 1'b0, 8'h24, 1'b0, 1'b0, 1'b0, 5'd5, 5'b00100};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL fwd_b_ex: got %h want %h", outs, exp);
        end
        step(1'b0, 20'h69825);
        exp = {2'b00, 2'b01, 1'b0, 8'h25, 1'b0, 1'b0, 1'b0, 5'd6, 5'b01101};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL fwd_b_chain: got %h want %h", outs, exp);
        end
    endtask

    task automatic test_two_back();
        logic [25:0] exp;
        step(1'b1, 20'h00000);
        step(1'b0, 20'h00C00);
        exp = {2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 5'b00000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL producer_r3: got %h want %h", outs, exp);
        end
        step(1'b0, 20'hD0000);
        exp = {2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 5'b11010};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL nop: got %h want %h", outs, exp);
        end
        step(1'b0, 20'h01C68);
        exp = {2'b10, 2'b00, 1'b0, 8'h68, 1'b0, 1'b0, 1'b0, 5'd7, 5'b00000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL fwd_a_mem: got %h want %h", outs, exp);
        end
        // Two consecutive producers of r3: the nearer one wins.
        step(1'b0, 20'h00C00);
        step(1'b0, 20'h00C00);
        exp = {2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 5'b00000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL producer_r3_again: got %h want %h", outs, exp);
        end
        step(1'b0, 20'h01C68);
        exp = {2'b01, 2'b00, 1'b0, 8'h68, 1'b0, 1'b0, 1'b0, 5'd7, 5'b00000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL fwd_priority: got %h want %h", outs, exp);
        end
    endtask

    task automatic test_memory();
        logic [25:0] exp;
        step(1'b1, 20'h00000);
        step(1'b0, 20'hC0C10);
        exp = {2'b00, 2'b00, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 5'd3, 5'b11000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL load: got %h want %h", outs, exp);
        end
        step(1'b0, 20'hC8C10);
        exp = {2'b01, 2'b00, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 5'd3, 5'b11001};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL store_after_load: got %h want %h", outs, exp);
        end
        step(1'b0, 20'h01C68);
        exp = {2'b10, 2'b00, 1'b0, 8'h68, 1'b0, 1'b0, 1'b0, 5'd7, 5'b00000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL store_no_write: got %h want %h", outs, exp);
        end
    endtask

    task automatic test_reg_zero();
        logic [25:0] exp;
        step(1'b1, 20'h00000);
        step(1'b0, 20'h00000);
        exp = '0;
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL r0_first: got %h want %h", outs, exp);
        end
        step(1'b0, 20'h00000);
        exp = {2'b01, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 5'b00000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL r0_forward: got %h want %h", outs, exp);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [25:0] exp;
        step(1'b1, 20'h00000);
        step(1'b0, 20'h00C00);
        step(1'b1, 20'h00C00);
        exp = '0;
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL mid_reset_outs: got %h want %h", outs, exp);
        end
        step(1'b0, 20'h01C68);
        exp = {2'b00, 2'b00, 1'b0, 8'h68, 1'b0, 1'b0, 1'b0, 5'd7, 5'b00000};
        n_cmp++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL mid_reset_consumer: got %h want %h", outs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        ins   = '0;
        test_reset();
        test_immediate_and_forwarding();
        test_two_back();
        test_memory();
        test_reg_zero();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
